// File: rtl/ctrl_decode_stage.sv
// LEGv8 main-control decode stage: decodes the IF/ID opcode, detects load-use hazards,
// and registers the control bundle into the ID/EX control register.
module ctrl_decode_stage #(
  parameter int unsigned OP_W       = 11,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned EXT_BRANCH = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [REG_W-1:0] in_rn,
  input  logic [REG_W-1:0] in_rm,
  input  logic [REG_W-1:0] in_rt,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_reg2loc,
  output logic             ex_memtoreg,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic             ex_alusrc,
  output logic             ex_branch_nz,
  output logic             ex_uncond,
  output logic [1:0]       ex_aluop,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic             reg2loc;
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic             alusrc;
    logic             branch_nz;
    logic             uncond;
    logic [1:0]       aluop;
    logic [REG_W-1:0] rd;
    logic             illegal;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] cnt_q;

  logic             dec_reg2loc, dec_memtoreg, dec_regwrite, dec_memread;
  logic             dec_memwrite, dec_branch, dec_alusrc, dec_branch_nz, dec_uncond;
  logic             dec_illegal;
  logic [1:0]       dec_aluop;
  logic             use_src1, use_src2;
  logic [REG_W-1:0] src2;
  logic             hazard;

  always_comb begin
    dec_reg2loc   = 1'b0;
    dec_memtoreg  = 1'b0;
    dec_regwrite  = 1'b0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_branch    = 1'b0;
    dec_alusrc    = 1'b0;
    dec_branch_nz = 1'b0;
    dec_uncond    = 1'b0;
    dec_illegal   = 1'b0;
    dec_aluop     = 2'b00;
    use_src1      = 1'b0;
    use_src2      = 1'b0;
    casez (in_op)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        dec_regwrite = 1'b1;
        dec_aluop    = 2'b10;
        use_src1     = 1'b1;
        use_src2     = 1'b1;
      end
      11'b11111000010: begin
        dec_memtoreg = 1'b1;
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_alusrc   = 1'b1;
        use_src1     = 1'b1;
      end
      11'b11111000000: begin
        dec_reg2loc  = 1'b1;
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        use_src1     = 1'b1;
        use_src2     = 1'b1;
      end
      11'b10110100???: begin
        dec_reg2loc = 1'b1;
        dec_branch  = 1'b1;
        dec_aluop   = 2'b01;
        use_src2    = 1'b1;
      end
      11'b10110101???: begin
        if (EXT_BRANCH != 0) begin
          dec_reg2loc   = 1'b1;
          dec_branch    = 1'b1;
          dec_branch_nz = 1'b1;
          dec_aluop     = 2'b01;
          use_src2      = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      11'b000101?????: begin
        if (EXT_BRANCH != 0) begin
          dec_uncond = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Stores and compare-branches read their data register through Rt.
  assign src2 = dec_reg2loc ? in_rt : in_rm;

  // XZR (all-ones specifier) is never a real producer.
  assign hazard = in_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '1) &
                  ((use_src1 & (ex_q.rd == in_rn)) | (use_src2 & (ex_q.rd == src2)));

  assign stall = hazard & ~flush;

  always_comb begin
    ex_d = '0;
    if (!flush && !stall && in_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.reg2loc   = dec_reg2loc;
      ex_d.memtoreg  = dec_memtoreg;
      ex_d.regwrite  = dec_regwrite;
      ex_d.memread   = dec_memread;
      ex_d.memwrite  = dec_memwrite;
      ex_d.branch    = dec_branch;
      ex_d.alusrc    = dec_alusrc;
      ex_d.branch_nz = dec_branch_nz;
      ex_d.uncond    = dec_uncond;
      ex_d.aluop     = dec_aluop;
      ex_d.rd        = in_rt;
      ex_d.illegal   = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg2loc   = ex_q.reg2loc;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_branch    = ex_q.branch;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_branch_nz = ex_q.branch_nz;
  assign ex_uncond    = ex_q.uncond;
  assign ex_aluop     = ex_q.aluop;
  assign ex_rd        = ex_q.rd;
  assign ex_illegal   = ex_q.illegal;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: two configurations (extended branches / wide counter and
// base ISA / 2-bit counter) share stimulus and are checked against an instruction-level model.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic       valid;
    logic [6:0] ctl;  // {reg2loc, memtoreg, regwrite, memread, memwrite, branch, alusrc}
    logic       bnz;
    logic       unc;
    logic [1:0] aluop;
    logic [4:0] rd;
    logic       illegal;
  } bundle_t;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpCbz  = 11'b10110100000;
  localparam logic [10:0] OpCbnz = 11'b10110101000;
  localparam logic [10:0] OpB    = 11'b00010100000;
  localparam logic [10:0] OpBad  = 11'b11111000011;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush;
  logic [10:0] in_op;
  logic [4:0]  in_rn, in_rm, in_rt;

  logic        st1, st0;
  logic        v1, r2l1, m2r1, rw1, mr1, mw1, br1, as1, bnz1, unc1, ill1;
  logic        v0, r2l0, m2r0, rw0, mr0, mw0, br0, as0, bnz0, unc0, ill0;
  logic [1:0]  alu1, alu0;
  logic [4:0]  rd1, rd0;
  logic [15:0] cnt1;
  logic [1:0]  cnt0;

  int tests = 0;
  int fails = 0;

  bundle_t     m1, m0;
  int unsigned c1, c0;
  bit          last_stall;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.OP_W(11), .REG_W(5), .EXT_BRANCH(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_rn(in_rn),
    .in_rm(in_rm), .in_rt(in_rt), .flush(flush), .stall(st1), .ex_valid(v1),
    .ex_reg2loc(r2l1), .ex_memtoreg(m2r1), .ex_regwrite(rw1), .ex_memread(mr1),
    .ex_memwrite(mw1), .ex_branch(br1), .ex_alusrc(as1), .ex_branch_nz(bnz1),
    .ex_uncond(unc1), .ex_aluop(alu1), .ex_rd(rd1), .ex_illegal(ill1), .stall_count(cnt1)
  );

  ctrl_decode_stage #(.OP_W(11), .REG_W(5), .EXT_BRANCH(0), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_rn(in_rn),
    .in_rm(in_rm), .in_rt(in_rt), .flush(flush), .stall(st0), .ex_valid(v0),
    .ex_reg2loc(r2l0), .ex_memtoreg(m2r0), .ex_regwrite(rw0), .ex_memread(mr0),
    .ex_memwrite(mw0), .ex_branch(br0), .ex_alusrc(as0), .ex_branch_nz(bnz0),
    .ex_uncond(unc0), .ex_aluop(alu0), .ex_rd(rd0), .ex_illegal(ill0), .stall_count(cnt0)
  );

  bundle_t d1, d0;
  assign d1 = {v1, r2l1, m2r1, rw1, mr1, mw1, br1, as1, bnz1, unc1, alu1, rd1, ill1};
  assign d0 = {v0, r2l0, m2r0, rw0, mr0, mw0, br0, as0, bnz0, unc0, alu0, rd0, ill0};

  // Instruction class: 0 illegal, 1 R-format, 2 LDUR, 3 STUR, 4 CBZ, 5 CBNZ, 6 B.
  function automatic int cls(input logic [10:0] op, input bit ext);
    logic [7:0] top8;
    logic [5:0] top6;
    top8 = op[10:3];
    top6 = op[10:5];
    if (op == OpAdd || op == OpSub || op == OpAnd || op == OpOrr) return 1;
    if (op == OpLdur) return 2;
    if (op == OpStur) return 3;
    if (top8 == 8'b10110100) return 4;
    if (top8 == 8'b10110101) return ext ? 5 : 0;
    if (top6 == 6'b000101) return ext ? 6 : 0;
    return 0;
  endfunction

  function automatic bundle_t dec(input logic [10:0] op, input bit ext, input logic [4:0] rt);
    bundle_t b;
    b = '0;
    b.valid = 1'b1;
    b.rd    = rt;
    case (cls(op, ext))
      1: begin b.ctl = 7'b0010000; b.aluop = 2'b10; end
      2: b.ctl = 7'b0111001;
      3: b.ctl = 7'b1000101;
      4: begin b.ctl = 7'b1000010; b.aluop = 2'b01; end
      5: begin b.ctl = 7'b1000010; b.aluop = 2'b01; b.bnz = 1'b1; end
      6: b.unc = 1'b1;
      default: b.illegal = 1'b1;
    endcase
    return b;
  endfunction

  // A load in EX whose destination is read by the instruction in ID forces a stall.
  function automatic bit hz(input bundle_t ex, input bit ext);
    int c;
    bit u1, u2;
    logic [4:0] s2;
    if (!in_valid || flush || !ex.valid || !ex.ctl[3] || ex.rd == 5'd31) return 1'b0;
    c  = cls(in_op, ext);
    u1 = (c == 1 || c == 2 || c == 3);
    u2 = (c == 1 || c == 3 || c == 4 || c == 5);
    s2 = (c == 3 || c == 4 || c == 5) ? in_rt : in_rm;
    return (u1 && ex.rd == in_rn) || (u2 && ex.rd == s2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [10:0] op, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [4:0] rt, input bit fl);
    in_valid = v;
    in_op    = op;
    in_rn    = rn;
    in_rm    = rm;
    in_rt    = rt;
    flush    = fl;
  endtask

  // Compare every output against the model, then advance the model across one edge.
  task automatic step();
    bit s1, s0;
    #1;
    s1 = hz(m1, 1'b1);
    s0 = hz(m0, 1'b0);
    check("ex_bundle_ext", 64'(d1), 64'(m1));
    check("ex_bundle_base", 64'(d0), 64'(m0));
    check("stall_ext", 64'(st1), 64'(s1));
    check("stall_base", 64'(st0), 64'(s0));
    check("count_ext", 64'(cnt1), 64'(c1));
    check("count_base", 64'(cnt0), 64'(c0));
    @(posedge clk);
    m1 = (flush || s1 || !in_valid) ? bundle_t'(0) : dec(in_op, 1'b1, in_rt);
    m0 = (flush || s0 || !in_valid) ? bundle_t'(0) : dec(in_op, 1'b0, in_rt);
    if (s1 && c1 < 65535) c1++;
    if (s0 && c0 < 3) c0++;
    last_stall = s1 || s0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m1 = '0;
    m0 = '0;
    c1 = 0;
    c0 = 0;
    last_stall = 1'b0;
  endtask

  function automatic logic [10:0] pick_op(input int k);
    case (k)
      0: return OpAdd;
      1: return OpSub;
      2: return OpAnd;
      3: return OpOrr;
      4, 5: return OpLdur;
      6: return OpStur;
      7: return OpCbz | 11'($urandom_range(0, 7));
      8: return OpCbnz | 11'($urandom_range(0, 7));
      9: return OpB | 11'($urandom_range(0, 31));
      10: return OpBad;
      default: return 11'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd2;
      1: return 5'd3;
      2: return 5'd7;
      3: return 5'd31;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    drive(0, '0, '0, '0, '0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(v1), 64'd0);
    check("reset_count", 64'(cnt1), 64'd0);
    reset = 1'b1;

    // Load-use with a real register, then with XZR.
    drive(1, OpLdur, 5'd1, 5'd0, 5'd3, 0); step();
    check("ldur_ctl", 64'({r2l1, m2r1, rw1, mr1, mw1, br1, as1}), 64'h39);
    drive(1, OpAdd, 5'd3, 5'd1, 5'd4, 0);
    #1 check("lu_stall", 64'(st1), 64'd1);
    step();
    check("lu_bubble", 64'(v1), 64'd0);
    check("lu_stall_gone", 64'(st1), 64'd0);
    step();
    check("lu_add_valid", 64'(v1), 64'd1);
    check("lu_add_aluop", 64'(alu1), 64'd2);
    check("lu_count", 64'(cnt1), 64'd1);
    drive(1, OpLdur, 5'd1, 5'd0, 5'd31, 0); step();
    drive(1, OpAdd, 5'd31, 5'd31, 5'd4, 0);
    #1 check("xzr_no_stall", 64'(st1), 64'd0);
    step();

    // Store data, compare-branch and unconditional branch after a load to X7.
    drive(1, OpLdur, 5'd1, 5'd0, 5'd7, 0); step();
    drive(1, OpStur, 5'd2, 5'd0, 5'd7, 0);
    #1 check("stur_rt_stall", 64'(st1), 64'd1);
    step(); step();
    drive(1, OpLdur, 5'd1, 5'd0, 5'd7, 0); step();
    drive(1, OpCbz, 5'd0, 5'd0, 5'd7, 0);
    #1 check("cbz_stall", 64'(st1), 64'd1);
    step(); step();
    drive(1, OpLdur, 5'd1, 5'd0, 5'd7, 0); step();
    drive(1, OpB, 5'd7, 5'd7, 5'd7, 0);
    #1 check("b_no_stall", 64'(st1), 64'd0);
    step();
    check("b_uncond", 64'(unc1), 64'd1);

    // Flush beats a hazard.
    drive(1, OpLdur, 5'd1, 5'd0, 5'd5, 0); step();
    drive(1, OpAdd, 5'd5, 5'd5, 5'd6, 1);
    #1 check("flush_no_stall", 64'(st1), 64'd0);
    step();
    check("flush_bubble", 64'(v1), 64'd0);
    check("flush_count", 64'(cnt1), 64'd3);

    // Illegal opcode and EXT_BRANCH gating.
    drive(1, OpBad, 5'd0, 5'd0, 5'd1, 0); step();
    check("bad_illegal", 64'(ill1), 64'd1);
    check("bad_valid", 64'(v1), 64'd1);
    drive(1, OpCbnz, 5'd0, 5'd0, 5'd1, 0); step();
    check("cbnz_ext", 64'({br1, bnz1, ill1}), 64'b110);
    check("cbnz_gated", 64'({br0, ill0, v0}), 64'b011);

    // Saturation of the 2-bit counter.
    reset = 1'b0; #1 model_reset(); @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, OpLdur, 5'd1, 5'd0, 5'd3, 0); step();
      drive(1, OpAdd, 5'd3, 5'd1, 5'd4, 0); step(); step();
    end
    check("sat_base", 64'(cnt0), 64'd3);
    check("sat_ext", 64'(cnt1), 64'd5);

    // Randomised traffic; the held instruction stays in IF/ID while stalled.
    drive(0, '0, '0, '0, '0, 0);
    for (int i = 0; i < 600; i++) begin
      if (last_stall) begin
        flush = ($urandom_range(0, 9) == 0);
      end else begin
        drive($urandom_range(0, 7) != 0, pick_op($urandom_range(0, 11)), pick_reg(),
              pick_reg(), pick_reg(), $urandom_range(0, 9) == 0);
      end
      step();
    end

    // Asynchronous reset mid-run with a valid instruction in EX.
    drive(1, OpLdur, 5'd1, 5'd0, 5'd3, 0); step();
    check("pre_reset_valid", 64'(v1), 64'd1);
    drive(1, OpAdd, 5'd3, 5'd1, 5'd4, 0);
    reset = 1'b0;
    #1;
    check("async_reset_bundle", 64'(d1), 64'd0);
    check("async_reset_stall", 64'(st1), 64'd0);
    check("async_reset_count", 64'({cnt1, cnt0}), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    check("redecode_after_reset", 64'({v1, alu1}), 64'b110);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, parametrised main-control stage for the pipelined LEGv8 core, sitting between the IF/ID and ID/EX pipeline registers. It decodes the 11-bit opcode into the control bundle, adds CBNZ and unconditional B when enabled, and latches the bundle into the ID/EX control register. It also detects load-use hazards with a stall/bubble, honours a branch flush, and keeps a saturating stall counter.

## Interface
- `OP_W`, 11, opcode field width; only 11 is legal.
- `REG_W`, 5, register specifier width.
- `EXT_BRANCH`, 1, 1 = decode CBNZ and B; 0 = both decode as illegal.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1: IF/ID holds a real instruction.
- `in_op` in OP_W: instruction[31:21].
- `in_rn`, `in_rm`, `in_rt` in REG_W each: instruction Rn, Rm, Rt/Rd fields.
- `flush` in 1: branch taken in MEM; squash the instruction in ID.
- `stall` out 1: combinational; IF/ID and PC hold while high.
- `ex_valid` out 1: ID/EX contains a real instruction.
- `ex_reg2loc`, `ex_memtoreg`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_branch`, `ex_alusrc` out 1 each: registered control bits.
- `ex_branch_nz` out 1: the branch is CBNZ.
- `ex_uncond` out 1: the instruction is B.
- `ex_aluop` out 2: ALU operation class.
- `ex_rd` out REG_W: registered `in_rt`, the destination.
- `ex_illegal` out 1: the instruction in ID/EX did not decode.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
Decode is combinational on `in_op`. Bit order is {Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUSrc}, then ALUOp. Every don't-care is driven 0.
- **ADD** 10001011000, **SUB** 11001011000, **AND** 10001010000, **ORR** 10101010000: 0010000, ALUOp 10.
- **LDUR** 11111000010: 0111001, ALUOp 00.
- **STUR** 11111000000: 1000101, ALUOp 00.
- **CBZ** 10110100xxx: 1000010, ALUOp 01.
- **CBNZ** 10110101xxx (EXT_BRANCH=1 only): as CBZ, plus branch_nz=1.
- **B** 000101xxxxx (EXT_BRANCH=1 only): uncond=1, all other bits 0, ALUOp 00.
- **Anything else**: all bits 0 and illegal=1. An illegal opcode still latches with valid=1 so the trap can be taken downstream.

Hazard detection:
- Source 1 is `in_rn`; it is used by the R-format ops, LDUR and STUR.
- Source 2 is `in_rt` when Reg2Loc=1, else `in_rm`; it is used by the R-format ops, STUR, CBZ and CBNZ.
- `stall` = `in_valid` & `ex_valid` & `ex_memread` & (`ex_rd` != 31) & (`ex_rd` matches a used source) & !`flush`.
- Register 31 (XZR) never causes a hazard.

ID/EX update on each rising edge, in priority order:
1. `flush` = 1: bubble. `ex_valid`=0, all control bits and `ex_illegal` are 0, and `ex_rd` is 0.
2. `stall` = 1: bubble, same as above.
3. `in_valid` = 0: bubble.
4. Otherwise: load the decoded bundle, with `ex_valid`=1 and `ex_rd`=`in_rt`.

Stall counter:
- Increments by 1 on every edge where `stall`=1.
- Saturates at 2^CNT_W−1.
- Cleared only by reset.

Reset (`reset` low, asynchronous): all `ex_*` outputs and `stall_count` go to 0 immediately. `stall` reads 0 because `ex_valid`=0. A reset asserted mid-stall discards the bubble state, and the held instruction re-decodes after release.

## Timing
- Decode-to-`ex_*` latency is 1 cycle; the `ex_*` outputs are glitch-free register outputs.
- `stall` is combinational from `in_*`, `flush` and the ID/EX registers, and settles in the same cycle. A load-use stall lasts exactly 1 cycle, because the bubble clears `ex_memread`.
- Back-to-back loads with a dependence produce a single stall per dependent consumer.
- If `flush` and a hazard occur together, `flush` wins: no stall and no count increment.
- The first edge after reset release loads the instruction normally if `in_valid`=1.

## Test plan
- **Reset:** hold `reset`=0 mid-run with `ex_valid`=1 → all `ex_*` outputs, `stall` and `stall_count` read 0 immediately, with no clock edge.
- **Decode sweep:** drive each legal opcode with EXT_BRANCH=1 → one cycle later the `ex_*` bundle matches the table. Drive 11111000011 → `ex_illegal`=1 and `ex_valid`=1.
- **Parameter gating:** EXT_BRANCH=0 and `in_op`=10110101000 → `ex_illegal`=1, `ex_branch`=0.
- **Load-use:**
  - LDUR with `in_rt`=3, then ADD with Rn=3 → `stall`=1 for 1 cycle, then a bubble with `ex_valid`=0, then ADD latched; `stall_count`=1.
  - Repeat with `in_rt`=31 → no stall.
- **Store data hazard:** LDUR with `in_rt`=7, then STUR with Rt=7 and Rn=2 → stall, because Reg2Loc selects Rt. CBZ Rt=7 → stall. B → no stall.
- **Flush priority:** a hazard condition with `flush`=1 in the same cycle → `stall`=0, the next `ex_valid`=0, and `stall_count` is unchanged.
- **Counter saturation:** with CNT_W=2, produce 5 stalls → `stall_count`=3.
